// File: rtl/vmul_pkg.sv
// Shared types for the quadrant-split multiplier: FSM states, phase
// counter type and the per-phase shift amount of each partial product.
package vmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PHASE_LAST = 2'd3;

  // Shift applied to the partial product of a phase: {0, H, H, 2H}.
  function automatic int unsigned shift_amt(input phase_t ph, input int unsigned h);
    case (ph)
      2'd0:       return 0;
      2'd1, 2'd2: return h;
      default:    return 2 * h;
    endcase
  endfunction

endpackage

// File: rtl/vmul_half.sv
// Combinational H x H -> WIDTH unsigned multiplier shared by all four phases.
module vmul_half #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH/2-1:0] i_x,
  input  logic [WIDTH/2-1:0] i_y,
  output logic [WIDTH-1:0]   o_p
);

  localparam int unsigned H = WIDTH / 2;

  assign o_p = {{H{1'b0}}, i_x} * {{H{1'b0}}, i_y};

endmodule

// File: rtl/vsplit4_mul.sv
// Iterative unsigned multiplier: latches a/b, accumulates the four
// half x half partial products (one per cycle) into a 2*WIDTH product.
// Optional macro VSPLIT4_PARTIALS_EN exposes the four registered partial
// products pp_tr/pp_br/pp_tl/pp_bl for an external cross-check.
module vsplit4_mul
  import vmul_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef VSPLIT4_PARTIALS_EN
  output logic [WIDTH-1:0]   pp_tl,
  output logic [WIDTH-1:0]   pp_tr,
  output logic [WIDTH-1:0]   pp_bl,
  output logic [WIDTH-1:0]   pp_br,
`endif
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned H = WIDTH / 2;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("vsplit4_mul: WIDTH must be even and >= 2");
  end

  state_e               r_state;
  state_e               w_state_nxt;
  phase_t               r_phase;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;

  logic                 w_accept;
  logic                 w_release;
  logic [H-1:0]         w_x;
  logic [H-1:0]         w_y;
  logic [WIDTH-1:0]     w_pp;
  logic [2*WIDTH-1:0]   w_pp_ext;
  logic [2*WIDTH-1:0]   w_pp_shift;

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // phase[0] picks the hi half of a, phase[1] the hi half of b
  assign w_x = r_phase[0] ? r_a[WIDTH-1:H] : r_a[H-1:0];
  assign w_y = r_phase[1] ? r_b[WIDTH-1:H] : r_b[H-1:0];

  vmul_half #(.WIDTH(WIDTH)) u_half (
    .i_x (w_x),
    .i_y (w_y),
    .o_p (w_pp)
  );

  assign w_pp_ext   = {{WIDTH{1'b0}}, w_pp};
  assign w_pp_shift = w_pp_ext << shift_amt(r_phase, H);
  assign product    = r_acc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; outputs depend on state only
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = MUL;
      end
      MUL: begin
        if (r_phase == PHASE_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, phase counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_phase <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_acc   <= '0;
      r_phase <= '0;
    end else if (r_state == MUL) begin
      r_acc   <= r_acc + w_pp_shift;
      r_phase <= r_phase + 2'd1;
    end
  end

`ifdef VSPLIT4_PARTIALS_EN
  // Capture each partial product as its phase completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_tr <= '0;
      pp_br <= '0;
      pp_tl <= '0;
      pp_bl <= '0;
    end else if (r_state == MUL) begin
      case (r_phase)
        2'd0:    pp_tr <= w_pp;
        2'd1:    pp_br <= w_pp;
        2'd2:    pp_tl <= w_pp;
        default: pp_bl <= w_pp;
      endcase
    end
  end
`endif

  // Unused-signal sink for the release strobe (kept for readability of the FSM)
  logic w_unused;
  assign w_unused = w_release;

endmodule
